// File: rtl/typing_round_ctrl.sv
// typing_round_ctrl: fetches words from the word ROM, presents them to the letter checker,
// and keeps score, misses and the round timer until timeout or too many misses.
module typing_round_ctrl #(
    parameter int WORD_COUNT    = 32,
    parameter int ADDR_W        = 5,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ROUND_SECS    = 60,
    parameter int FAIL_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pass_in,
    input  logic              fail_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [19:0]       rom_data,
    output logic [19:0]       cword,
    output logic              checker_reset,
    output logic [7:0]        score,
    output logic [3:0]        misses,
    output logic [6:0]        secs_left,
    output logic              playing,
    output logic              game_over
);
    localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [19:0]       cword_n;
    logic [7:0]        score_n;
    logic [3:0]        misses_n;
    logic [6:0]        secs_n;
    logic [TW-1:0]     tick, tick_n;
    logic              load_cnt, load_cnt_n;
    logic              pass_q, fail_q;
    logic              pass_ev, fail_ev, sec_end;

    always_comb begin
        state_n    = state;
        addr_n     = rom_addr;
        cword_n    = cword;
        score_n    = score;
        misses_n   = misses;
        secs_n     = secs_left;
        tick_n     = tick;
        load_cnt_n = load_cnt;
        pass_ev    = pass_in & ~pass_q;
        fail_ev    = fail_in & ~fail_q;
        sec_end    = tick == TW'(TICKS_PER_SEC - 1);
        case (state)
            IDLE, DONE: if (start) begin
                state_n    = LOAD;
                score_n    = '0;
                misses_n   = '0;
                secs_n     = 7'(ROUND_SECS);
                tick_n     = '0;
                addr_n     = '0;
                load_cnt_n = 1'b0;
            end
            LOAD: begin
                load_cnt_n = ~load_cnt;
                if (load_cnt) begin
                    cword_n = rom_data;
                    state_n = PLAY;
                end
            end
            PLAY: if (fail_ev) begin
                misses_n   = misses + 4'd1;
                state_n    = misses_n == 4'(FAIL_LIMIT) ? DONE : LOAD;
                load_cnt_n = 1'b0;
            end else if (pass_ev) begin
                score_n    = score == 8'hff ? score : score + 8'd1;
                addr_n     = rom_addr == ADDR_W'(WORD_COUNT - 1) ? '0 : rom_addr + ADDR_W'(1);
                state_n    = LOAD;
                load_cnt_n = 1'b0;
            end
        endcase
        // Timeout wins over any pass/fail acted on in the same cycle.
        if (state == LOAD || state == PLAY) begin
            tick_n = sec_end ? '0 : tick + TW'(1);
            if (sec_end && secs_left != 7'd0) begin
                secs_n = secs_left - 7'd1;
                if (secs_n == 7'd0) begin
                    state_n  = DONE;
                    score_n  = score;
                    misses_n = misses;
                    addr_n   = rom_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rom_addr      <= '0;
            cword         <= '0;
            score         <= '0;
            misses        <= '0;
            secs_left     <= 7'(ROUND_SECS);
            tick          <= '0;
            load_cnt      <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            checker_reset <= 1'b1;
            playing       <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            rom_addr      <= addr_n;
            cword         <= cword_n;
            score         <= score_n;
            misses        <= misses_n;
            secs_left     <= secs_n;
            tick          <= tick_n;
            load_cnt      <= load_cnt_n;
            pass_q        <= pass_in;
            fail_q        <= fail_in;
            checker_reset <= state_n != PLAY;
            playing       <= state_n == PLAY;
            game_over     <= state_n == DONE;
        end
    end
endmodule
